// File: rtl/note_recorder_pkg.sv
// Shared note codes, LED patterns, default sizing and recorder states for note_recorder.
package note_recorder_pkg;

    localparam logic [3:0] MUSIC0    = 4'd0;
    localparam logic [3:0] MUSIC1    = 4'd1;
    localparam logic [3:0] MUSIC2    = 4'd2;
    localparam logic [3:0] MUSIC3    = 4'd3;
    localparam logic [3:0] MUSIC4    = 4'd4;
    localparam logic [3:0] MUSIC5    = 4'd5;
    localparam logic [3:0] MUSIC6    = 4'd6;
    localparam logic [3:0] MUSIC7    = 4'd7;
    localparam logic [3:0] NOTE_TERM = 4'b1111;

    localparam logic [6:0] LED_OFF = 7'b0000000;
    localparam logic [6:0] LED1    = 7'b0000001;
    localparam logic [6:0] LED2    = 7'b0000010;
    localparam logic [6:0] LED3    = 7'b0000100;
    localparam logic [6:0] LED4    = 7'b0001000;
    localparam logic [6:0] LED5    = 7'b0010000;
    localparam logic [6:0] LED6    = 7'b0100000;
    localparam logic [6:0] LED7    = 7'b1000000;

    localparam int SONG_LEN_DEF = 56;
    localparam int TICK_DEF     = 10000000;

    localparam logic [3:0] DUR_MAX = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        DONE = 2'd2
    } rec_state_t;

endpackage

// File: rtl/note_recorder_key_encoder.sv
// Note-key priority encoder (lowest key wins). With NOTE_DEBOUNCE_EN defined the keys
// first pass a 2-flop synchronizer and a DEB_CYC-cycle stability filter.
module key_encoder
    import note_recorder_pkg::*;
`ifdef NOTE_DEBOUNCE_EN
#(
    parameter int DEB_CYC = 200000
)
`endif
(
`ifdef NOTE_DEBOUNCE_EN
    input  logic       clk,
    input  logic       reset,
`endif
    input  logic [6:0] key_in,
    output logic [3:0] note,
    output logic [6:0] led
);

    logic [6:0] keys;

`ifdef NOTE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYC + 1);

    logic [6:0]       sync_p1, sync_p2, cand, keys_deb;
    logic [CNT_W-1:0] stable_cnt;

    // A candidate pattern is accepted only after it has stayed put for DEB_CYC cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p1    <= '0;
            sync_p2    <= '0;
            cand       <= '0;
            keys_deb   <= '0;
            stable_cnt <= '0;
        end else begin
            sync_p1 <= key_in;
            sync_p2 <= sync_p1;
            if (sync_p2 != cand) begin
                cand       <= sync_p2;
                stable_cnt <= '0;
            end else if (cand != keys_deb) begin
                if (stable_cnt == CNT_W'(DEB_CYC - 1)) begin
                    keys_deb   <= cand;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    assign keys = keys_deb;
`else
    assign keys = key_in;
`endif

    always_comb begin
        note = MUSIC0;
        led  = LED_OFF;
        casez (keys)
            7'b??????1: begin note = MUSIC1; led = LED1; end
            7'b?????10: begin note = MUSIC2; led = LED2; end
            7'b????100: begin note = MUSIC3; led = LED3; end
            7'b???1000: begin note = MUSIC4; led = LED4; end
            7'b??10000: begin note = MUSIC5; led = LED5; end
            7'b?100000: begin note = MUSIC6; led = LED6; end
            7'b1000000: begin note = MUSIC7; led = LED7; end
            default:    begin note = MUSIC0; led = LED_OFF; end
        endcase
    end

endmodule

// File: rtl/note_recorder.sv
// Live note recorder: packs played notes (code, duration, octave) into a playback song buffer.
// Optional key debouncing is enabled by defining NOTE_DEBOUNCE_EN.
module note_recorder
    import note_recorder_pkg::*;
#(
    parameter int SONG_LEN = SONG_LEN_DEF,
    parameter int TICK     = TICK_DEF
`ifdef NOTE_DEBOUNCE_EN
    ,
    parameter int DEB_CYC  = 200000
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            key_in,
    input  logic [1:0]            octave_in,
    input  logic                  rec_start,
    input  logic                  rec_stop,
    output logic [SONG_LEN*4-1:0] song_packed,
    output logic [SONG_LEN*4-1:0] time_packed,
    output logic [SONG_LEN*2-1:0] octave_packed,
    output logic [5:0]            rec_len,
    output logic                  recording,
    output logic                  full,
    output logic [3:0]            note_to_play,
    output logic [6:0]            led_out
);

    localparam int                TICK_W    = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK - 1);
    localparam logic [5:0]        LEN_FULL  = 6'(SONG_LEN - 1);

    function automatic logic [3:0] dur_clip(input logic [3:0] units_v);
        return (units_v == 4'd0) ? 4'd1 : units_v;
    endfunction

    logic [3:0]        enc_note;
    logic [6:0]        enc_led;
    rec_state_t        state;
    logic              start_prev, stop_prev, start_edge, stop_edge;
    logic              pend_vld;
    logic [3:0]        pend_note;
    logic [1:0]        pend_oct;
    logic [TICK_W-1:0] tick, tick_base, tick_n;
    logic [3:0]        units, units_base, units_n;
    logic              in_rec, note_chg, open_new, sat, do_commit, hits_full;
    logic [3:0]        c_dur;
    logic [5:0]        len_n;

`ifdef NOTE_DEBOUNCE_EN
    key_encoder #(.DEB_CYC(DEB_CYC)) u_key_encoder (
        .clk    (clk),
        .reset  (reset),
        .key_in (key_in),
        .note   (enc_note),
        .led    (enc_led)
    );
`else
    key_encoder u_key_encoder (
        .key_in (key_in),
        .note   (enc_note),
        .led    (enc_led)
    );
`endif

    // The cycle that opens an entry already counts as its first tick
    always_comb begin
        start_edge = rec_start & ~start_prev;
        stop_edge  = rec_stop & ~stop_prev;
        in_rec     = (state == REC) && !start_edge;
        note_chg   = pend_vld && ((enc_note != pend_note) || (octave_in != pend_oct));
        open_new   = in_rec && !stop_edge && ((!pend_vld && (enc_note != MUSIC0)) || note_chg);
        tick_base  = open_new ? '0 : tick;
        units_base = open_new ? 4'd0 : units;
        if (tick_base == TICK_LAST) begin
            tick_n  = '0;
            units_n = units_base + 4'd1;
        end else begin
            tick_n  = tick_base + TICK_W'(1);
            units_n = units_base;
        end
        sat       = in_rec && !stop_edge && pend_vld && !note_chg && (units_n == DUR_MAX);
        do_commit = in_rec && (stop_edge ? (pend_vld && (pend_note != MUSIC0)) : (note_chg || sat));
        c_dur     = sat ? DUR_MAX : dur_clip(units);
        len_n     = rec_len + 6'd1;
        hits_full = do_commit && (len_n == LEN_FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            note_to_play <= MUSIC0;
            led_out      <= LED_OFF;
        end else begin
            note_to_play <= enc_note;
            led_out      <= enc_led;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            start_prev    <= 1'b0;
            stop_prev     <= 1'b0;
            pend_vld      <= 1'b0;
            pend_note     <= MUSIC0;
            pend_oct      <= 2'd0;
            tick          <= '0;
            units         <= 4'd0;
            rec_len       <= 6'd0;
            song_packed   <= '0;
            time_packed   <= '0;
            octave_packed <= '0;
        end else begin
            start_prev <= rec_start;
            stop_prev  <= rec_stop;
            if (start_edge) begin
                state            <= REC;
                rec_len          <= 6'd0;
                song_packed[3:0] <= NOTE_TERM;
                tick             <= '0;
                units            <= 4'd0;
                pend_vld         <= 1'b0;
            end else if (state == REC) begin
                if (do_commit) rec_len <= len_n;
                if (stop_edge || hits_full) begin
                    state    <= DONE;
                    pend_vld <= 1'b0;
                end else begin
                    if (open_new) begin
                        pend_vld  <= 1'b1;
                        pend_note <= enc_note;
                        pend_oct  <= octave_in;
                    end
                    if (sat) begin
                        tick  <= '0;
                        units <= 4'd0;
                    end else if (pend_vld || open_new) begin
                        tick  <= tick_n;
                        units <= units_n;
                    end
                end
            end
            // Committed entry lands at rec_len; the slot after it becomes the terminator
            for (int i = 0; i < SONG_LEN; i++) begin
                if (do_commit && (i == int'(rec_len))) begin
                    song_packed[i*4 +: 4]   <= pend_note;
                    time_packed[i*4 +: 4]   <= c_dur;
                    octave_packed[i*2 +: 2] <= pend_oct;
                end
                if (do_commit && (i == int'(len_n))) song_packed[i*4 +: 4] <= NOTE_TERM;
            end
        end
    end

    assign recording = (state == REC);
    assign full      = (rec_len == LEN_FULL);

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: directed scenarios plus random key play against a run-length song model.
module tb_note_recorder;

    localparam int SL = 8;
    localparam int TK = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [6:0]    key_in = '0;
    logic [1:0]    octave_in = '0;
    logic          rec_start = 1'b0;
    logic          rec_stop = 1'b0;
    logic [SL*4-1:0] song_packed, time_packed;
    logic [SL*2-1:0] octave_packed;
    logic [5:0]    rec_len;
    logic          recording, full;
    logic [3:0]    note_to_play;
    logic [6:0]    led_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    note_recorder #(
        .SONG_LEN (SL),
        .TICK     (TK)
`ifdef NOTE_DEBOUNCE_EN
        ,
        .DEB_CYC  (3)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_in        (key_in),
        .octave_in     (octave_in),
        .rec_start     (rec_start),
        .rec_stop      (rec_stop),
        .song_packed   (song_packed),
        .time_packed   (time_packed),
        .octave_packed (octave_packed),
        .rec_len       (rec_len),
        .recording     (recording),
        .full          (full),
        .note_to_play  (note_to_play),
        .led_out       (led_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifndef NOTE_DEBOUNCE_EN
    // Model: a song is a list of runs; a run's duration is its cycle count / TICK, min 1, split at 15 units
    int m_song[SL];
    int m_time[SL];
    int m_oct[SL];
    int m_len, m_state, m_live;
    bit m_start_prev, m_stop_prev;
    bit run_open;
    int run_note, run_oct, run_cyc;

    function automatic int enc(input logic [6:0] k);
        for (int b = 0; b < 7; b++) if (k[b]) return b + 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SL; i++) begin m_song[i] = 0; m_time[i] = 0; m_oct[i] = 0; end
        m_len = 0; m_state = 0; m_live = 0;
        m_start_prev = 0; m_stop_prev = 0; run_open = 0; run_cyc = 0;
    endtask

    task automatic emit(input int n, input int d, input int o);
        m_song[m_len] = n; m_time[m_len] = d; m_oct[m_len] = o;
        m_len++;
        m_song[m_len] = 15;
        if (m_len == SL - 1) begin m_state = 2; run_open = 0; end
    endtask

    task automatic model_edge();
        bit st_e, sp_e;
        int n, units;
        st_e = rec_start && !m_start_prev;
        sp_e = rec_stop && !m_stop_prev;
        n = enc(key_in);
        m_live = n;
        m_start_prev = rec_start;
        m_stop_prev = rec_stop;
        units = (run_cyc / TK > 0) ? run_cyc / TK : 1;
        if (st_e) begin
            m_state = 1; m_len = 0; m_song[0] = 15; run_open = 0;
        end else if (m_state == 1) begin
            if (sp_e) begin
                if (run_open && run_note != 0) emit(run_note, units, run_oct);
                m_state = 2; run_open = 0;
            end else if (!run_open) begin
                if (n != 0) begin run_open = 1; run_note = n; run_oct = octave_in; run_cyc = 1; end
            end else if (n != run_note || int'(octave_in) != run_oct) begin
                emit(run_note, units, run_oct);
                if (m_state == 1) begin run_note = n; run_oct = octave_in; run_cyc = 1; end
            end else begin
                run_cyc++;
                if (run_cyc == 15 * TK) begin emit(run_note, 15, run_oct); run_cyc = 0; end
            end
        end
    endtask

    task automatic compare_all();
        logic [SL*4-1:0] es, et;
        logic [SL*2-1:0] eo;
        for (int i = 0; i < SL; i++) begin
            es[i*4 +: 4] = 4'(m_song[i]);
            et[i*4 +: 4] = 4'(m_time[i]);
            eo[i*2 +: 2] = 2'(m_oct[i]);
        end
        chk("song_packed", 64'(song_packed), 64'(es));
        chk("time_packed", 64'(time_packed), 64'(et));
        chk("octave_packed", 64'(octave_packed), 64'(eo));
        chk("rec_len", 64'(rec_len), 64'(m_len));
        chk("recording", 64'(recording), 64'(m_state == 1));
        chk("full", 64'(full), 64'(m_len == SL - 1));
        chk("note_to_play", 64'(note_to_play), 64'(m_live));
        chk("led_out", 64'(led_out), 64'((m_live == 0) ? 0 : (1 << (m_live - 1))));
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic rst_cyc();
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [6:0] rand_key();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 7'd0;
        if (r == 3) return 7'($urandom);
        return 7'(1 << $urandom_range(0, 6));
    endfunction
`endif

    initial begin
`ifndef NOTE_DEBOUNCE_EN
        logic [1:0] o2;
        int len, r;
        model_reset();
        rst_cyc();
        rst_cyc();
        chk("reset_song", 64'(song_packed), 64'd0);
        chk("reset_rec_len", 64'(rec_len), 64'd0);
        chk("reset_recording", 64'(recording), 64'd0);
        chk("reset_note", 64'(note_to_play), 64'd0);
        reset = 1'b1;

        // Two notes then stop
        o2 = 2'($urandom);
        octave_in = o2;
        rec_start = 1'b1; cyc(); rec_start = 1'b0;
        key_in = 7'b0000100; repeat (12) cyc();
        key_in = 7'b0100000; repeat (4) cyc();
        rec_stop = 1'b1; cyc(); rec_stop = 1'b0; key_in = 7'd0; cyc();
        chk("t2_len", 64'(rec_len), 64'd2);
        chk("t2_n0", 64'(song_packed[3:0]), 64'd3);
        chk("t2_d0", 64'(time_packed[3:0]), 64'd3);
        chk("t2_o0", 64'(octave_packed[1:0]), 64'(o2));
        chk("t2_n1", 64'(song_packed[7:4]), 64'd6);
        chk("t2_d1", 64'(time_packed[7:4]), 64'd1);
        chk("t2_term", 64'(song_packed[11:8]), 64'hF);

        // Multi-key press held past saturation
        rec_start = 1'b1; cyc(); rec_start = 1'b0;
        key_in = 7'b0000101; cyc();
        chk("t3_note", 64'(note_to_play), 64'd1);
        chk("t3_led", 64'(led_out), 64'b0000001);
        repeat (63) cyc();
        key_in = 7'd0; cyc();
        rec_stop = 1'b1; cyc(); rec_stop = 1'b0; cyc();
        chk("t3_len", 64'(rec_len), 64'd2);
        chk("t3_d0", 64'(time_packed[3:0]), 64'd15);
        chk("t3_d1", 64'(time_packed[7:4]), 64'd1);

        // Fill the buffer
        rec_start = 1'b1; cyc(); rec_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            key_in = 7'(1 << k);
            repeat (4) cyc();
        end
        key_in = 7'd0; cyc();
        chk("t4_full", 64'(full), 64'd1);
        chk("t4_recording", 64'(recording), 64'd0);
        chk("t4_term", 64'(song_packed[31:28]), 64'hF);
        key_in = 7'b0000100; repeat (5) cyc();
        chk("t4_len_after", 64'(rec_len), 64'd7);
        key_in = 7'd0; cyc();

        // Start and stop together from DONE, then stop over a rest
        rec_start = 1'b1; rec_stop = 1'b1; cyc();
        rec_start = 1'b0; rec_stop = 1'b0;
        chk("t5_recording", 64'(recording), 64'd1);
        chk("t5_len", 64'(rec_len), 64'd0);
        key_in = 7'b0000010; repeat (4) cyc();
        key_in = 7'd0; repeat (3) cyc();
        rec_stop = 1'b1; cyc(); rec_stop = 1'b0; cyc();
        chk("t5_len_rest", 64'(rec_len), 64'd1);
        chk("t5_term", 64'(song_packed[7:4]), 64'hF);

        // Random play with occasional start/stop edges
        rec_start = 1'b1; cyc(); rec_start = 1'b0;
        for (int s = 0; s < 60; s++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin rec_start = 1'b1; cyc(); rec_start = 1'b0; end
            else if (r == 1) begin rec_stop = 1'b1; cyc(); rec_stop = 1'b0; end
            key_in = rand_key();
            if ($urandom_range(0, 3) == 0) octave_in = 2'($urandom);
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(55, 70) : $urandom_range(1, 12);
            repeat (len) cyc();
        end

        // Reset while recording with three committed entries
        key_in = 7'd0; rec_start = 1'b1; cyc(); rec_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            key_in = 7'(1 << k);
            repeat (5) cyc();
        end
        chk("t1_len_before", 64'(rec_len), 64'd3);
        reset = 1'b0;
        rst_cyc();
        chk("t1_song", 64'(song_packed), 64'd0);
        chk("t1_time", 64'(time_packed), 64'd0);
        chk("t1_oct", 64'(octave_packed), 64'd0);
        chk("t1_len", 64'(rec_len), 64'd0);
        chk("t1_note", 64'(note_to_play), 64'd0);
        reset = 1'b1;
`else
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("deb_reset_note", 64'(note_to_play), 64'd0);
        rec_start = 1'b1; @(posedge clk); #1 rec_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        key_in = 7'b0000001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        key_in = 7'd0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("deb_glitch_note", 64'(note_to_play), 64'd0);
            chk("deb_glitch_led", 64'(led_out), 64'd0);
            chk("deb_glitch_len", 64'(rec_len), 64'd0);
        end
        key_in = 7'b0000001;
        repeat (14) @(posedge clk);
        #1;
        chk("deb_hold_note", 64'(note_to_play), 64'd1);
        chk("deb_hold_led", 64'(led_out), 64'd1);
        key_in = 7'd0;
        repeat (14) @(posedge clk);
        #1;
        chk("deb_release_note", 64'(note_to_play), 64'd0);
        rec_stop = 1'b1; @(posedge clk); #1 rec_stop = 1'b0;
        @(posedge clk); #1;
        chk("deb_len", 64'(rec_len), 64'd1);
        chk("deb_n0", 64'(song_packed[3:0]), 64'd1);
        chk("deb_term", 64'(song_packed[7:4]), 64'hF);
        chk("deb_recording", 64'(recording), 64'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
